inst_fetch: RTL and testbench
=============================

INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'hbfc00000, is the first fetch address after reset.
REQ-002 clk  input  1  single clock; all state changes on the rising edge.
REQ-003 resetn  input  1  asynchronous, active-low reset.
REQ-004 inst_req  output  1  instruction memory request valid.
REQ-005 inst_addr  output  32  request address, word-aligned.
REQ-006 inst_addr_ok  input  1  memory accepts the request this cycle.
REQ-007 inst_rdata  input  32  returned instruction word.
REQ-008 inst_data_ok  input  1  inst_rdata valid this cycle.
REQ-009 if_valid  output  1  if_inst/if_pc hold a fetched instruction for decode.
REQ-010 if_inst  output  32  fetched instruction word, driven to the decoder inst input.
REQ-011 if_pc  output  32  address of if_inst.
REQ-012 id_allow_in  input  1  decode accepts the held instruction this cycle.
REQ-013 br_valid  input  1  decode holds a valid instruction this cycle, qualifying jump_short/jump_long.
REQ-014 jump_short  input  1  taken conditional branch from decode.
REQ-015 br_target  input  32  target for jump_short.
REQ-016 jump_long  input  1  taken j/jal/jr-class jump from decode.
REQ-017 j_target  input  32  target for jump_long.

Function
REQ-018 The FSM SHALL have states IDLE, REQ, WAIT, HOLD; IDLE is entered only by reset.
REQ-019 IDLE SHALL move to REQ on the first clock edge after resetn deasserts, with pc = RESET_PC.
REQ-020 In REQ, inst_req = 1 and inst_addr = pc; inst_req and inst_addr SHALL stay stable until inst_addr_ok = 1.
REQ-021 REQ with inst_addr_ok = 1 SHALL move to WAIT; inst_req = 0 in every state except REQ.
REQ-022 At most one request SHALL be outstanding.
REQ-023 WAIT with inst_data_ok = 1 SHALL move to HOLD, registering if_inst = inst_rdata and if_pc = pc.
REQ-024 if_valid SHALL be 1 exactly in HOLD.
REQ-025 inst_data_ok SHALL be ignored outside WAIT.
REQ-026 Handoff: HOLD with id_allow_in = 1 SHALL move to REQ with pc = next_pc.
REQ-027 HOLD with id_allow_in = 0 SHALL keep if_valid, if_inst and if_pc unchanged.
REQ-028 Without a pending redirect, next_pc = pc + 4, modulo 2^32 (wrap at 32'hfffffffc to 0).
REQ-029 Redirect capture: when br_valid & (jump_short | jump_long), target = jump_long ? j_target : br_target; jump_long has priority.
REQ-030 The captured target SHALL be stored in redir_pc and redir_pend set to 1.
REQ-031 Branch delay slot: the instruction in flight or held at capture (branch PC + 4) SHALL still be fetched and handed off.
REQ-032 At the next handoff, next_pc = redir_pc and redir_pend clears.
REQ-033 If capture and handoff occur in the same cycle, next_pc SHALL be the incoming target, and redir_pend stays 0.
REQ-034 A second capture while redir_pend = 1 SHALL overwrite redir_pc (last wins).
REQ-035 Targets SHALL be stored with bits [1:0] forced to 2'b00.
REQ-036 jump_short and jump_long SHALL be ignored when br_valid = 0.
REQ-037 Minimum handoff latency from entering REQ is 3 cycles, with addr_ok in the REQ cycle and data_ok in the following cycle.

Reset
REQ-038 resetn = 0 SHALL immediately force: state IDLE, inst_req 0, if_valid 0, if_inst 0, if_pc 0, pc RESET_PC, redir_pc 0, redir_pend 0.
REQ-039 Reset in any state, including mid-WAIT, SHALL abandon the outstanding request; a late inst_data_ok SHALL not produce if_valid.

Verification
REQ-040 Cold start: release resetn; addr_ok = 1 in the first REQ cycle, data_ok next cycle with rdata 32'h24080001 -> inst_addr = 32'hbfc00000, then if_valid = 1, if_pc = 32'hbfc00000, if_inst = 32'h24080001.
REQ-041 Stall: hold addr_ok = 0 for 3 cycles, then id_allow_in = 0 for 5 cycles in HOLD -> inst_addr stays stable; if_valid/if_inst stay constant; no second inst_req.
REQ-042 Delay slot: branch at 32'hbfc00004 asserts br_valid & jump_short, br_target = 32'hbfc00100, while 32'hbfc00008 is in WAIT -> fetch order 32'hbfc00008 then 32'hbfc00100.
REQ-043 Priority and alignment: jump_short and jump_long together, br_target = 32'h100, j_target = 32'h203 -> next fetch after the delay slot is 32'h200.
REQ-044 Same-cycle capture and handoff: redirect in the handoff cycle to 32'hbfc00040 -> next inst_addr = 32'hbfc00040; redir_pend remains 0.
REQ-045 Reset mid-WAIT, then data_ok pulsed while resetn = 0 and in IDLE -> if_valid stays 0; first new request = 32'hbfc00000.

Source files
------------

// File: rtl/inst_fetch.sv
// Instruction fetch stage: single-outstanding request FSM with delay-slot
// aware redirect capture feeding the decode stage.
module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'hbfc00000
) (
    input  logic        clk,
    input  logic        resetn,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_addr_ok,
    input  logic [31:0] inst_rdata,
    input  logic        inst_data_ok,
    output logic        if_valid,
    output logic [31:0] if_inst,
    output logic [31:0] if_pc,
    input  logic        id_allow_in,
    input  logic        br_valid,
    input  logic        jump_short,
    input  logic [31:0] br_target,
    input  logic        jump_long,
    input  logic [31:0] j_target
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_HOLD
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_redir_pc;
    logic        r_redir_pend;
    logic        r_req;
    logic        r_valid;
    logic [31:0] r_if_inst;
    logic [31:0] r_if_pc;

    logic        w_capture;
    logic [31:0] w_target;
    logic        w_handoff;
    logic [31:0] w_next_pc;

    assign w_capture = br_valid & (jump_short | jump_long);
    assign w_target  = (jump_long ? j_target : br_target) & 32'hffff_fffc;
    assign w_handoff = (r_state == S_HOLD) & id_allow_in;

    // A target arriving in the handoff cycle bypasses the pending slot.
    always_comb begin
        w_next_pc = r_pc + 32'd4;
        if (w_capture)
            w_next_pc = w_target;
        else if (r_redir_pend)
            w_next_pc = r_redir_pc;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state      <= S_IDLE;
            r_pc         <= RESET_PC;
            r_redir_pc   <= 32'd0;
            r_redir_pend <= 1'b0;
            r_req        <= 1'b0;
            r_valid      <= 1'b0;
            r_if_inst    <= 32'd0;
            r_if_pc      <= 32'd0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    r_state <= S_REQ;
                    r_req   <= 1'b1;
                end
                S_REQ: begin
                    if (inst_addr_ok) begin
                        r_state <= S_WAIT;
                        r_req   <= 1'b0;
                    end
                end
                S_WAIT: begin
                    if (inst_data_ok) begin
                        r_state   <= S_HOLD;
                        r_valid   <= 1'b1;
                        r_if_inst <= inst_rdata;
                        r_if_pc   <= r_pc;
                    end
                end
                S_HOLD: begin
                    if (id_allow_in) begin
                        r_state <= S_REQ;
                        r_req   <= 1'b1;
                        r_valid <= 1'b0;
                        r_pc    <= w_next_pc;
                    end
                end
                default: r_state <= S_IDLE;
            endcase

            if (w_handoff) begin
                r_redir_pend <= 1'b0;
            end else if (w_capture) begin
                r_redir_pc   <= w_target;
                r_redir_pend <= 1'b1;
            end
        end
    end

    assign inst_req  = r_req;
    assign inst_addr = r_pc;
    assign if_valid  = r_valid;
    assign if_inst   = r_if_inst;
    assign if_pc     = r_if_pc;

endmodule

// File: tb/tb_inst_fetch.sv
// Directed scenarios followed by a randomized fetch-stream run checked
// against a transaction-level model of the expected address sequence.
module tb_inst_fetch;

    logic        clk = 1'b0;
    logic        resetn;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic [31:0] inst_rdata;
    logic        inst_data_ok;
    logic        if_valid;
    logic [31:0] if_inst;
    logic [31:0] if_pc;
    logic        id_allow_in;
    logic        br_valid;
    logic        jump_short;
    logic [31:0] br_target;
    logic        jump_long;
    logic [31:0] j_target;

    int checks = 0;
    int failures = 0;

    inst_fetch #(.RESET_PC(32'hbfc00000)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .inst_req     (inst_req),
        .inst_addr    (inst_addr),
        .inst_addr_ok (inst_addr_ok),
        .inst_rdata   (inst_rdata),
        .inst_data_ok (inst_data_ok),
        .if_valid     (if_valid),
        .if_inst      (if_inst),
        .if_pc        (if_pc),
        .id_allow_in  (id_allow_in),
        .br_valid     (br_valid),
        .jump_short   (jump_short),
        .br_target    (br_target),
        .jump_long    (jump_long),
        .j_target     (j_target)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_br();
        br_valid   = 1'b0;
        jump_short = 1'b0;
        jump_long  = 1'b0;
    endtask

    task automatic do_fetch(input logic [31:0] d);
        inst_addr_ok = 1'b1;
        step();
        inst_addr_ok = 1'b0;
        inst_data_ok = 1'b1;
        inst_rdata   = d;
        step();
        inst_data_ok = 1'b0;
    endtask

    task automatic handoff();
        id_allow_in = 1'b1;
        step();
        id_allow_in = 1'b0;
    endtask

    function automatic logic [31:0] memw(input logic [31:0] a);
        return (a * 32'h9e3779b1) ^ 32'h1234_5678;
    endfunction

    logic [31:0] exp_next;
    logic [31:0] cur;
    logic [31:0] redir;
    logic        pend;
    logic [31:0] tgt;
    logic        cap;
    int          phase;
    int          lat;

    initial begin
        resetn = 1'b0;
        inst_addr_ok = 1'b0;
        inst_data_ok = 1'b0;
        inst_rdata = 32'd0;
        id_allow_in = 1'b0;
        br_target = 32'd0;
        j_target = 32'd0;
        clr_br();
        #3;
        chk("rst_req", {31'd0, inst_req}, 32'd0);
        chk("rst_valid", {31'd0, if_valid}, 32'd0);
        chk("rst_inst", if_inst, 32'd0);
        chk("rst_pc", if_pc, 32'd0);

        // Cold start
        @(negedge clk);
        resetn = 1'b1;
        step();
        chk("cold_req", {31'd0, inst_req}, 32'd1);
        chk("cold_addr", inst_addr, 32'hbfc00000);
        inst_addr_ok = 1'b1;
        step();
        inst_addr_ok = 1'b0;
        chk("cold_req_drop", {31'd0, inst_req}, 32'd0);
        inst_data_ok = 1'b1;
        inst_rdata = 32'h24080001;
        step();
        inst_data_ok = 1'b0;
        chk("cold_valid", {31'd0, if_valid}, 32'd1);
        chk("cold_pc", if_pc, 32'hbfc00000);
        chk("cold_inst", if_inst, 32'h24080001);

        // Stall on both handshakes
        handoff();
        for (int i = 0; i < 3; i++) begin
            chk("stall_req", {31'd0, inst_req}, 32'd1);
            chk("stall_addr", inst_addr, 32'hbfc00004);
            step();
        end
        do_fetch(32'h8c090000);
        for (int i = 0; i < 5; i++) begin
            chk("hold_valid", {31'd0, if_valid}, 32'd1);
            chk("hold_inst", if_inst, 32'h8c090000);
            chk("hold_noreq", {31'd0, inst_req}, 32'd0);
            step();
        end
        chk("hold_pc", if_pc, 32'hbfc00004);

        // Delay slot
        handoff();
        chk("ds_addr", inst_addr, 32'hbfc00008);
        inst_addr_ok = 1'b1;
        step();
        inst_addr_ok = 1'b0;
        br_valid = 1'b1;
        jump_short = 1'b1;
        br_target = 32'hbfc00100;
        inst_data_ok = 1'b1;
        inst_rdata = 32'h0;
        step();
        clr_br();
        inst_data_ok = 1'b0;
        chk("ds_pc", if_pc, 32'hbfc00008);
        handoff();
        chk("br_addr", inst_addr, 32'hbfc00100);

        // Priority and alignment
        br_valid = 1'b1;
        jump_short = 1'b1;
        jump_long = 1'b1;
        br_target = 32'h100;
        j_target = 32'h203;
        do_fetch(32'h1);
        clr_br();
        chk("pri_ds_pc", if_pc, 32'hbfc00100);
        handoff();
        chk("pri_addr", inst_addr, 32'h00000200);

        // Same-cycle capture and handoff
        do_fetch(32'h2);
        chk("same_pc", if_pc, 32'h00000200);
        br_valid = 1'b1;
        jump_long = 1'b1;
        j_target = 32'hbfc00040;
        handoff();
        clr_br();
        chk("same_addr", inst_addr, 32'hbfc00040);
        do_fetch(32'h3);
        handoff();
        chk("same_nopend", inst_addr, 32'hbfc00044);

        // Ignored jumps without br_valid, then wrap at the top of memory
        jump_long = 1'b1;
        j_target = 32'h0000_1000;
        do_fetch(32'h4);
        handoff();
        jump_long = 1'b0;
        chk("nobrv_addr", inst_addr, 32'hbfc00048);
        br_valid = 1'b1;
        jump_long = 1'b1;
        j_target = 32'hfffffffd;
        do_fetch(32'h5);
        clr_br();
        handoff();
        chk("wrap_tgt", inst_addr, 32'hfffffffc);
        do_fetch(32'h6);
        handoff();
        chk("wrap_zero", inst_addr, 32'h00000000);

        // Reset mid-WAIT
        inst_addr_ok = 1'b1;
        step();
        inst_addr_ok = 1'b0;
        #2;
        resetn = 1'b0;
        #1;
        chk("mrst_req", {31'd0, inst_req}, 32'd0);
        chk("mrst_valid", {31'd0, if_valid}, 32'd0);
        inst_data_ok = 1'b1;
        inst_rdata = 32'hdeadbeef;
        step();
        chk("mrst_late", {31'd0, if_valid}, 32'd0);
        resetn = 1'b1;
        step();
        inst_data_ok = 1'b0;
        chk("mrst_valid2", {31'd0, if_valid}, 32'd0);
        chk("mrst_req2", {31'd0, inst_req}, 32'd1);
        chk("mrst_addr", inst_addr, 32'hbfc00000);

        // Randomized stream against the fetch-order model
        exp_next = 32'hbfc00000;
        pend = 1'b0;
        redir = 32'd0;
        cur = 32'd0;
        phase = 0;
        lat = 0;
        for (int c = 0; c < 800; c++) begin
            inst_addr_ok = 1'b0;
            inst_data_ok = 1'b0;
            id_allow_in = 1'b0;
            inst_rdata = $urandom;
            br_valid = ($urandom_range(0, 4) == 0);
            jump_short = ($urandom_range(0, 1) == 0);
            jump_long = ($urandom_range(0, 2) == 0);
            br_target = $urandom;
            j_target = $urandom;
            cap = br_valid & (jump_short | jump_long);
            tgt = jump_long ? {j_target[31:2], 2'b00}
                            : {br_target[31:2], 2'b00};
            if (phase == 0) begin
                chk("r_req", {31'd0, inst_req}, 32'd1);
                chk("r_addr", inst_addr, exp_next);
                chk("r_novalid", {31'd0, if_valid}, 32'd0);
                inst_data_ok = ($urandom_range(0, 3) == 0);
                if ($urandom_range(0, 2) != 0) begin
                    inst_addr_ok = 1'b1;
                    cur = exp_next;
                    lat = $urandom_range(0, 3);
                    phase = 1;
                end
            end else if (phase == 1) begin
                chk("r_single", {31'd0, inst_req}, 32'd0);
                chk("r_novalid_w", {31'd0, if_valid}, 32'd0);
                if (lat == 0) begin
                    inst_data_ok = 1'b1;
                    inst_rdata = memw(cur);
                    phase = 2;
                end else begin
                    lat--;
                end
            end else begin
                chk("r_valid", {31'd0, if_valid}, 32'd1);
                chk("r_pc", if_pc, cur);
                chk("r_inst", if_inst, memw(cur));
                chk("r_noreq", {31'd0, inst_req}, 32'd0);
                inst_data_ok = ($urandom_range(0, 3) == 0);
                if ($urandom_range(0, 1) == 0) begin
                    id_allow_in = 1'b1;
                    phase = 0;
                end
            end
            if (id_allow_in) begin
                exp_next = cap ? tgt : (pend ? redir : cur + 32'd4);
                pend = 1'b0;
            end else if (cap) begin
                redir = tgt;
                pend = 1'b1;
            end
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
